div_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M divide/remainder operations (ALUOP DIV 5'b01111, DIVU 5'b10000, REM 5'b10001, REMU 5'b10010) that the single-cycle ALU does not implement. It sits beside the ALU in the EX stage. It accepts a divide request, stalls the pipeline while a radix-2 restoring divider iterates for 32 cycles, and returns a 32-bit result with a one-cycle DONE pulse. Multiply ops stay in the ALU and are ignored here.

---
 rtl/div_sequencer_if.sv | 21 ++
 rtl/div_sequencer.sv | 141 ++++++++++++++
 tb/tb_div_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// EX-stage handshake between the pipeline and the multi-cycle divide sequencer.
interface div_sequencer_if;
    logic        START;
    logic [4:0]  ALUOP;
    logic [31:0] OPERAND1;
    logic [31:0] OPERAND2;
    logic        FLUSH;
    logic        STALL;
    logic [31:0] RESULT;
    logic        DONE;

    modport master (
        output START, ALUOP, OPERAND1, OPERAND2, FLUSH,
        input  STALL, RESULT, DONE
    );

    modport slave (
        input  START, ALUOP, OPERAND1, OPERAND2, FLUSH,
        output STALL, RESULT, DONE
    );
endinterface

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring divider, 32 iterations,
// stalls the pipeline while busy and pulses DONE with a registered RESULT.
module div_sequencer (
    input logic             CLK,
    input logic             RESET,
    div_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_DIVU = 5'b10000;
    localparam logic [4:0] OP_REM  = 5'b10001;
    localparam logic [4:0] OP_REMU = 5'b10010;

    state_t      state, next_state;
    logic [5:0]  counter;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic        is_rem, is_signed, neg_q, neg_r;
    logic [31:0] result_q;
    logic        done_q;

    logic        div_req, req_signed, req_rem, special;
    logic [31:0] special_val, mag1, mag2;
    logic [32:0] shifted, trial, new_rem;
    logic [31:0] new_quo, sel, final_val;
    logic        stall;

    always_comb begin
        div_req    = bus.START && (bus.ALUOP == OP_DIV || bus.ALUOP == OP_DIVU ||
                                   bus.ALUOP == OP_REM || bus.ALUOP == OP_REMU);
        req_signed = (bus.ALUOP == OP_DIV) || (bus.ALUOP == OP_REM);
        req_rem    = (bus.ALUOP == OP_REM) || (bus.ALUOP == OP_REMU);
        special    = 1'b0;
        special_val = '0;
        if (bus.OPERAND2 == '0) begin
            special     = 1'b1;
            special_val = req_rem ? bus.OPERAND1 : '1;
        end else if (req_signed && bus.OPERAND1 == 32'h8000_0000 && bus.OPERAND2 == '1) begin
            special     = 1'b1;
            special_val = req_rem ? '0 : 32'h8000_0000;
        end
        mag1 = (req_signed && bus.OPERAND1[31]) ? -bus.OPERAND1 : bus.OPERAND1;
        mag2 = (req_signed && bus.OPERAND2[31]) ? -bus.OPERAND2 : bus.OPERAND2;
    end

    // One restoring step: shift {rem,quo} left, keep the subtraction if it did not borrow.
    always_comb begin
        shifted = {rem[31:0], quo[31]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[32]) begin
            new_rem = trial;
            new_quo = {quo[30:0], 1'b1};
        end else begin
            new_rem = shifted;
            new_quo = {quo[30:0], 1'b0};
        end
        sel       = is_rem ? new_rem[31:0] : new_quo;
        final_val = (is_signed && (is_rem ? neg_r : neg_q)) ? -sel : sel;
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (div_req) begin
                    stall      = 1'b1;
                    next_state = special ? FINISH : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (counter == 6'd1) next_state = FINISH;
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.FLUSH) begin
            next_state = IDLE;
            stall      = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            counter   <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            is_rem    <= 1'b0;
            is_signed <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= 1'b0;
            if (!bus.FLUSH) begin
                case (state)
                    IDLE: begin
                        if (div_req) begin
                            if (special) begin
                                result_q <= special_val;
                                done_q   <= 1'b1;
                            end else begin
                                is_rem    <= req_rem;
                                is_signed <= req_signed;
                                neg_q     <= bus.OPERAND1[31] ^ bus.OPERAND2[31];
                                neg_r     <= bus.OPERAND1[31];
                                rem       <= '0;
                                quo       <= mag1;
                                divisor   <= mag2;
                                counter   <= 6'd32;
                            end
                        end
                    end
                    CALC: begin
                        rem     <= new_rem;
                        quo     <= new_quo;
                        counter <= counter - 6'd1;
                        if (counter == 6'd1) begin
                            result_q <= final_val;
                            done_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                counter <= '0;
            end
        end
    end

    assign bus.STALL  = !RESET && stall;
    assign bus.RESULT = result_q;
    assign bus.DONE   = done_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: results, latency, stall span,
// special cases, back-to-back issue, flush and reset aborts.
module tb_div_sequencer;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_DIVU = 5'b10000;
    localparam logic [4:0] OP_REM  = 5'b10001;
    localparam logic [4:0] OP_REMU = 5'b10010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    div_sequencer_if bus ();

    div_sequencer dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int stalls;
        logic got;
        @(negedge clk);
        bus.START = 1'b1; bus.ALUOP = op; bus.OPERAND1 = a; bus.OPERAND2 = b;
        #1 check({tag, "_stall_req"}, {31'b0, bus.STALL}, 32'd1);
        lat = 0; stalls = 1; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                bus.START = 1'b0;
                bus.OPERAND1 = $urandom;
                bus.OPERAND2 = $urandom;
            end
            lat++;
            if (bus.DONE) got = 1'b1;
            else if (bus.STALL) stalls++;
        end
        check({tag, "_done"}, {31'b0, got}, 32'd1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_stall_cycles"}, stalls, exp_lat);
        check({tag, "_result"}, bus.RESULT, exp);
        check({tag, "_stall_finish"}, {31'b0, bus.STALL}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'b0, bus.DONE}, 32'd0);
    endtask

    initial begin
        int dones;
        int stalls;
        bus.START = 1'b1; bus.ALUOP = OP_DIVU; bus.OPERAND1 = 32'd9; bus.OPERAND2 = 32'd3;
        bus.FLUSH = 1'b0;
        #12;
        check("rst_result", bus.RESULT, 32'h0);
        check("rst_done", {31'b0, bus.DONE}, 32'd0);
        check("rst_stall", {31'b0, bus.STALL}, 32'd0);
        bus.START = 1'b0;
        @(negedge clk); rst = 1'b0;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("div_5_0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0",   OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        run_op("divu_10_3",  OP_DIVU, 32'd10, 32'd3, 32'd3, 33);

        // Non-divide ops with START must be ignored.
        @(negedge clk);
        bus.START = 1'b1; bus.ALUOP = OP_ADD; bus.OPERAND1 = 32'd1; bus.OPERAND2 = 32'd0;
        #1 check("add_stall", {31'b0, bus.STALL}, 32'd0);
        @(posedge clk); #1;
        check("add_done", {31'b0, bus.DONE}, 32'd0);
        bus.ALUOP = OP_MUL;
        #1 check("mul_stall", {31'b0, bus.STALL}, 32'd0);
        @(posedge clk); #1;
        check("mul_done", {31'b0, bus.DONE}, 32'd0);
        check("mul_stall_after", {31'b0, bus.STALL}, 32'd0);
        bus.START = 1'b0;

        // Flush at CALC cycle 10.
        @(negedge clk);
        bus.START = 1'b1; bus.ALUOP = OP_DIVU; bus.OPERAND1 = 32'd1000; bus.OPERAND2 = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus.START = 1'b0;
        end
        check("flush_pre_stall", {31'b0, bus.STALL}, 32'd1);
        bus.FLUSH = 1'b1;
        #1 check("flush_stall", {31'b0, bus.STALL}, 32'd0);
        @(posedge clk); #1;
        bus.FLUSH = 1'b0;
        check("flush_done", {31'b0, bus.DONE}, 32'd0);
        check("flush_result", bus.RESULT, 32'd3);
        dones = 0; stalls = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.DONE) dones++;
            if (bus.STALL) stalls++;
        end
        check("flush_no_done", dones, 0);
        check("flush_no_stall", stalls, 0);
        check("flush_result_hold", bus.RESULT, 32'd3);

        // Reset pulse mid-CALC.
        @(negedge clk);
        bus.START = 1'b1; bus.ALUOP = OP_DIVU; bus.OPERAND1 = 32'd1000; bus.OPERAND2 = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus.START = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst_result", bus.RESULT, 32'h0);
        check("midrst_done", {31'b0, bus.DONE}, 32'd0);
        check("midrst_stall", {31'b0, bus.STALL}, 32'd0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.DONE) dones++;
        end
        check("midrst_no_done", dones, 0);

        run_op("recover_divu_1000_3", OP_DIVU, 32'd1000, 32'd3, 32'd333, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
